// File: rtl/ula_pkg.sv
// Shared constants and types for the slice-serial ALU: opcodes, FSM states, default slice width.
package ula_pkg;

    localparam int unsigned ULA_SLICE_DEF = 4;

    // Function selects (arithmetic when m=0, logic when m=1)
    localparam logic [3:0] ULA_SOMA  = 4'b1001;
    localparam logic [3:0] ULA_SUB   = 4'b0110;
    localparam logic [3:0] ULA_XOR   = 4'b0110;
    localparam logic [3:0] ULA_NOT_A = 4'b0000;
    localparam logic [3:0] ULA_ZERO  = 4'b0011;
    localparam logic [3:0] ULA_UNS   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ula_state_e;

    typedef struct packed {
        logic [3:0] s;
        logic       m;
        logic       c_in;
    } ula_ctrl_t;

endpackage

// File: rtl/ula_fatia.sv
// Combinational ALU slice: 16-function table on SLICE bits, with carry-out and carry into the slice MSB.
module ula_fatia
    import ula_pkg::*;
#(
    parameter int unsigned SLICE = ULA_SLICE_DEF
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic [3:0]       s_i,
    input  logic             m_i,
    input  logic             c_i,
    output logic [SLICE-1:0] f_o_c,
    output logic             co_o_c,
    output logic             cmsb_o_c
);

    logic [SLICE-1:0] t1;
    logic [SLICE-1:0] t2;
    logic [SLICE:0]   full;

    assign t1 = a_i | (b_i & {SLICE{s_i[0]}}) | (~b_i & {SLICE{s_i[1]}});
    assign t2 = (a_i & b_i & {SLICE{s_i[3]}}) | (a_i & ~b_i & {SLICE{s_i[2]}});
    assign full = (SLICE+1)'(t1) + (SLICE+1)'(t2) + (SLICE+1)'(c_i);

    // Carry into the MSB recovered from the sum bit, avoiding a per-bit ripple loop
    always_comb begin
        f_o_c    = '0;
        co_o_c   = 1'b0;
        cmsb_o_c = 1'b0;
        if (m_i) begin
            f_o_c = ~(t1 ^ t2);
        end else begin
            f_o_c    = full[SLICE-1:0];
            co_o_c   = full[SLICE];
            cmsb_o_c = full[SLICE-1] ^ t1[SLICE-1] ^ t2[SLICE-1];
        end
    end

endmodule

// File: rtl/ula_serial_fatias.sv
// Multi-cycle ALU: latches operands, computes one SLICE-bit slice per clock LSB first, then holds the result.
module ula_serial_fatias
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = ULA_SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             v_out,
    output logic             zero,
    output logic             a_eq_b
);

    localparam int unsigned NUM_SLICES = WIDTH / SLICE;
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    ula_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    ula_ctrl_t        ctrl_q, ctrl_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             c_out_q, c_out_d;
    logic             v_out_q, v_out_d;
    logic             zero_q, zero_d;
    logic             a_eq_b_q, a_eq_b_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0]      bit_off;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic             sl_cin;
    logic [SLICE-1:0] sl_f;
    logic             sl_co;
    logic             sl_cmsb;

    assign bit_off = 32'(idx_q) * 32'(SLICE);
    assign sl_a    = a_q[bit_off +: SLICE];
    assign sl_b    = b_q[bit_off +: SLICE];
    // Slice 0 takes the latched c_in; later slices take the rippled carry
    assign sl_cin  = (idx_q == '0) ? ctrl_q.c_in : carry_q;

    ula_fatia #(
        .SLICE(SLICE)
    ) u_fatia (
        .a_i      (sl_a),
        .b_i      (sl_b),
        .s_i      (ctrl_q.s),
        .m_i      (ctrl_q.m),
        .c_i      (sl_cin),
        .f_o_c    (sl_f),
        .co_o_c   (sl_co),
        .cmsb_o_c (sl_cmsb)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        ctrl_d      = ctrl_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        f_d         = f_q;
        c_out_d     = c_out_q;
        v_out_d     = v_out_q;
        zero_d      = zero_q;
        a_eq_b_d    = a_eq_b_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    ctrl_d     = '{s: s, m: m, c_in: c_in};
                    carry_d    = c_in;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                f_d[bit_off +: SLICE] = sl_f;
                carry_d = sl_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    c_out_d     = sl_co;
                    v_out_d     = sl_cmsb ^ sl_co;
                    zero_d      = (f_d == '0);
                    a_eq_b_d    = (a_q == b_q);
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            f_q         <= '0;
            c_out_q     <= 1'b0;
            v_out_q     <= 1'b0;
            zero_q      <= 1'b0;
            a_eq_b_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            f_q         <= f_d;
            c_out_q     <= c_out_d;
            v_out_q     <= v_out_d;
            zero_q      <= zero_d;
            a_eq_b_q    <= a_eq_b_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign c_out     = c_out_q;
    assign v_out     = v_out_q;
    assign zero      = zero_q;
    assign a_eq_b    = a_eq_b_q;

endmodule

// File: doc/ula_serial_fatias.md
Name: ula_serial_fatias

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit 74181-style ALU.
- Accepts WIDTH-bit operands, then processes one SLICE-bit slice per clock, LSB first, rippling the carry through a register.
- Provides the full 16-function arithmetic/logic table, carry-out, signed overflow, zero and a_eq_b flags.
- Uses a valid/ready handshake on both sides. It sits between the operand register file and result writeback in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a positive multiple of SLICE.
- SLICE, 4, bits processed per cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  4  function select.
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- c_in  in  1  carry-in; 1 adds one (arithmetic only).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- c_out  out  1  carry out of MSB.
- v_out  out  1  signed overflow.
- zero  out  1  f == 0.
- a_eq_b  out  1  latched a == latched b.

Behaviour:
- Reset is asynchronous and active-low and acts on every register. It forces:
  - state IDLE;
  - in_ready=1, out_valid=0;
  - f=0, c_out=0, v_out=0, zero=0, a_eq_b=0;
  - slice index 0, carry register 0.
- Per-bit terms, using latched a, b and s:
  - t1 = a | (b & s[0]) | (~b & s[1])
  - t2 = (a & b & s[3]) | (a & ~b & s[2])
- Arithmetic mode (m=0): f = t1 + t2 + c_in, computed slice-wise. The carry into slice 0 is c_in; the carry into slice k is the carry out of slice k-1.
- Logic mode (m=1): f = ~(t1 ^ t2). c_out=0 and v_out=0; the carry register is ignored.
- State machine:
  - IDLE:
    - in_ready=1.
    - On in_valid, latch a, b, s, m and c_in; set carry register to c_in and slice index to 0; go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each cycle, compute slice idx, write it to f[idx*SLICE +: SLICE] and update the carry register.
    - On the last slice (idx = WIDTH/SLICE-1), record c_out and v_out = carry into MSB ^ carry out of MSB (arithmetic only).
    - Go to DONE.
  - DONE:
    - out_valid=1.
    - f, c_out, v_out, zero and a_eq_b are stable.
    - On out_ready, go to IDLE with out_valid=0 in the next cycle.
- Latency: accept edge + WIDTH/SLICE BUSY cycles; out_valid rises on the cycle after the last slice. Throughput is one operation per WIDTH/SLICE+2 cycles.
- Flag timing:
  - zero and a_eq_b are computed from the final f and the latched operands.
  - They are valid whenever out_valid=1.
- Input handling:
  - in_valid while in_ready=0 is ignored; operands are not sampled.
  - Changing a, b, s, m or c_in after acceptance has no effect.
  - out_ready while out_valid=0 is ignored.
- Outputs hold their last values in IDLE until the next result overwrites them.
- f slices are written in place during BUSY. Consumers only sample f when out_valid=1.
- WIDTH == SLICE is legal: one BUSY cycle.
- All arithmetic wraps modulo 2^WIDTH.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. No partial result appears.

Decomposition:
- Package ula_pkg holds:
  - the opcode constants for s (e.g. ULA_SOMA=4'b1001, ULA_SUB=4'b0110, ULA_XOR=4'b0110 under m=1);
  - the state enum typedef (IDLE, BUSY, DONE);
  - the default SLICE.
- Sub-module ula_fatia is purely combinational, parametrised by SLICE. It takes a slice, b slice, s, m and carry-in, and returns the f slice, carry-out and carry into the slice MSB.
- The top level holds the FSM, operand registers, index counter, carry register and flags.

Test Plan (WIDTH=16, SLICE=4):
1. Add: a=0x00FF, b=0x0001, s=1001, m=0, c_in=0 -> after 4 BUSY cycles f=0x0100, c_out=0, v_out=0, zero=0, a_eq_b=0.
2. Subtract, equal operands: a=b=0x1234, s=0110, m=0, c_in=1 -> f=0x0000, c_out=1, zero=1, a_eq_b=1.
3. Overflow: a=0x7FFF, b=0x0001, s=1001, m=0, c_in=0 -> f=0x8000, v_out=1, c_out=0.
4. Logic sweep: a=0xF0F0, b=0xFF00, m=1, s=0110 -> f=0x0FF0; s=0000 -> f=0x0F0F; s=0011 -> f=0x0000, zero=1; s=1100 -> f=0xFFFF; c_out=0 throughout.
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid -> f and flags stable, in_ready=0, second in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
6. Reset mid-op: deassert rst_n during the 2nd BUSY cycle -> immediately out_valid=0, f=0, in_ready=1; the next operation computes correctly from slice 0.
